// File: rtl/reg_file_dbg_pkg.sv
// Shared constants and dump FSM state type for the
// RV32I register file with debug dump engine.
package reg_file_dbg_pkg;

  localparam int XLEN          = 32;
  localparam int NREG          = 32;
  localparam int BYTES_PER_REG = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_SEND  = 2'd2
  } dump_st_e;

endpackage

// File: rtl/rf_dump_ctrl.sv
// Debug dump engine: snapshots one register at a time
// and streams it out little-endian over valid/ready.
module rf_dump_ctrl
  import reg_file_dbg_pkg::*;
#(
  parameter int DUMP_LAST = 31
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            DUMP_REQ,
  input  logic            DBG_READY,
  input  logic [XLEN-1:0] i_rdata,
  output logic [4:0]      o_raddr,
  output logic            DUMP_BUSY,
  output logic            DBG_VALID,
  output logic [7:0]      DBG_DATA
);

  localparam logic [4:0] LAST = 5'(DUMP_LAST);

  dump_st_e        r_state;
  dump_st_e        w_next;
  logic [4:0]      r_idx;
  logic [1:0]      r_cnt;
  logic [XLEN-1:0] r_shadow;
  logic            w_xfer;

  assign w_xfer    = (r_state == ST_SEND) && DBG_READY;
  assign o_raddr   = r_idx;
  assign DBG_VALID = (r_state == ST_SEND);
  assign DUMP_BUSY = (r_state != ST_IDLE);
  assign DBG_DATA  = DBG_VALID ? r_shadow[7:0] : 8'h00;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (DUMP_REQ) w_next = ST_LATCH;
      ST_LATCH: w_next = ST_SEND;
      ST_SEND: begin
        if (w_xfer && r_cnt == 2'd3)
          w_next = (r_idx == LAST) ? ST_IDLE : ST_LATCH;
      end
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_idx    <= '0;
      r_cnt    <= '0;
      r_shadow <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (DUMP_REQ) r_idx <= '0;
        end
        ST_LATCH: begin
          r_shadow <= i_rdata;
          r_cnt    <= '0;
        end
        ST_SEND: begin
          if (w_xfer) begin
            if (r_cnt != 2'd3) begin
              r_shadow <= r_shadow >> 8;
              r_cnt    <= r_cnt + 2'd1;
            end else if (r_idx != LAST) begin
              r_idx <= r_idx + 5'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/reg_file_dbg.sv
// 32x32 register file, one-hot write port, two async
// read ports, sticky bad-select flag and dump engine.
module reg_file_dbg
  import reg_file_dbg_pkg::*;
#(
  parameter int DUMP_LAST = 31
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            WE,
  input  logic [NREG-1:0] WSEL,
  input  logic [XLEN-1:0] WD,
  input  logic [4:0]      RA1,
  input  logic [4:0]      RA2,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  input  logic            DUMP_REQ,
  output logic            DUMP_BUSY,
  output logic [7:0]      DBG_DATA,
  output logic            DBG_VALID,
  input  logic            DBG_READY,
  output logic            SEL_ERR
);

  logic [XLEN-1:0] r_regs [NREG];
  logic            r_sel_err;
  logic            w_onehot;
  logic            w_wr_ok;
  logic [4:0]      w_dump_addr;
  logic [XLEN-1:0] w_dump_data;

  // x & (x-1) clears the lowest set bit
  assign w_onehot = (WSEL != '0) &&
                    ((WSEL & (WSEL - NREG'(1))) == '0);
  assign w_wr_ok  = WE && w_onehot;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_wr_ok) begin
      for (int i = 1; i < NREG; i++)
        if (WSEL[i]) r_regs[i] <= WD;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)              r_sel_err <= 1'b0;
    else if (WE && !w_onehot) r_sel_err <= 1'b1;
  end

  assign SEL_ERR     = r_sel_err;
  assign RD1         = r_regs[RA1];
  assign RD2         = r_regs[RA2];
  assign w_dump_data = r_regs[w_dump_addr];

  rf_dump_ctrl #(
    .DUMP_LAST (DUMP_LAST)
  ) u_dump (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .DUMP_REQ  (DUMP_REQ),
    .DBG_READY (DBG_READY),
    .i_rdata   (w_dump_data),
    .o_raddr   (w_dump_addr),
    .DUMP_BUSY (DUMP_BUSY),
    .DBG_VALID (DBG_VALID),
    .DBG_DATA  (DBG_DATA)
  );

endmodule

// File: tb/tb_reg_file_dbg.sv
// Directed + randomized bench for reg_file_dbg with
// an array-based reference model of the register file.
module tb_reg_file_dbg;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        WE = 1'b0;
  logic [31:0] WSEL = '0;
  logic [31:0] WD = '0;
  logic [4:0]  RA1 = '0;
  logic [4:0]  RA2 = '0;
  logic [31:0] RD1, RD2;
  logic        DUMP_REQ = 1'b0;
  logic        DUMP_BUSY;
  logic [7:0]  DBG_DATA;
  logic        DBG_VALID;
  logic        DBG_READY = 1'b0;
  logic        SEL_ERR;

  int total = 0;
  int bad = 0;
  logic [31:0] model [32];
  logic [7:0]  rx [$];
  logic [7:0]  expq [$];

  reg_file_dbg #(.DUMP_LAST(31)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .WE        (WE),
    .WSEL      (WSEL),
    .WD        (WD),
    .RA1       (RA1),
    .RA2       (RA2),
    .RD1       (RD1),
    .RD2       (RD2),
    .DUMP_REQ  (DUMP_REQ),
    .DUMP_BUSY (DUMP_BUSY),
    .DBG_DATA  (DBG_DATA),
    .DBG_VALID (DBG_VALID),
    .DBG_READY (DBG_READY),
    .SEL_ERR   (SEL_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic wr_reg(input int i, input logic [31:0] d);
    WE = 1'b1;
    WSEL = 32'(1) << i;
    WD = d;
    @(posedge CLK);
    @(negedge CLK);
    WE = 1'b0;
    if (i != 0) model[i] = d;
  endtask

  task automatic build_exp();
    expq.delete();
    for (int r = 0; r < 32; r++)
      for (int b = 0; b < 4; b++)
        expq.push_back(8'(model[r] >> (8 * b)));
  endtask

  // Called at a negedge; issues DUMP_REQ and follows the stream.
  task automatic dump_run(input bit rnd, input bit wr3,
                          input int abort_at,
                          output int cyc, output int nrx);
    logic [31:0] w3;
    bit          wrote;
    logic        pv, pr;
    logic [7:0]  pd;
    wrote = 1'b0;
    pv = 1'b0;
    pr = 1'b0;
    pd = '0;
    w3 = $urandom;
    if (wr3) model[3] = w3;
    build_exp();
    rx.delete();
    DUMP_REQ = 1'b1;
    @(posedge CLK);
    cyc = 1;
    for (int k = 0; k < 4000; k++) begin
      @(negedge CLK);
      DUMP_REQ = 1'b0;
      WE = 1'b0;
      if (!DUMP_BUSY) break;
      if (pv && !pr) begin
        chk("hold_valid", 32'(DBG_VALID), 32'd1);
        chk("hold_data", 32'(DBG_DATA), 32'(pd));
      end
      DBG_READY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (abort_at >= 0 && rx.size() == abort_at && DBG_VALID) begin
        #2 RST_N = 1'b0;
        #1;
        chk("abort_valid", 32'(DBG_VALID), 32'd0);
        chk("abort_busy", 32'(DUMP_BUSY), 32'd0);
        chk("abort_data", 32'(DBG_DATA), 32'd0);
        nrx = rx.size();
        DBG_READY = 1'b0;
        return;
      end
      if (wr3 && !wrote && rx.size() == 8 && DBG_VALID) begin
        WE = 1'b1;
        WSEL = 32'h8;
        WD = w3;
        wrote = 1'b1;
      end
      if (rnd && rx.size() == 40) DUMP_REQ = 1'b1;
      if (DBG_VALID && DBG_READY) rx.push_back(DBG_DATA);
      pv = DBG_VALID;
      pr = DBG_READY;
      pd = DBG_DATA;
      @(posedge CLK);
      cyc++;
    end
    chk("dump_end_busy", 32'(DUMP_BUSY), 32'd0);
    nrx = rx.size();
    for (int i = 0; i < rx.size() && i < expq.size(); i++)
      chk($sformatf("byte%0d", i), 32'(rx[i]), 32'(expq[i]));
    DBG_READY = 1'b0;
    WE = 1'b0;
  endtask

  initial begin
    int cyc, n, we, idx;
    logic [31:0] d;
    foreach (model[i]) model[i] = '0;

    // reset values
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RA1 = 5'd7;
    RA2 = 5'd31;
    #1;
    chk("rst_rd1", RD1, 32'd0);
    chk("rst_rd2", RD2, 32'd0);
    chk("rst_valid", 32'(DBG_VALID), 32'd0);
    chk("rst_data", 32'(DBG_DATA), 32'd0);
    chk("rst_busy", 32'(DUMP_BUSY), 32'd0);
    chk("rst_selerr", 32'(SEL_ERR), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    // write x5, read old then new
    @(negedge CLK);
    RA1 = 5'd5;
    WE = 1'b1;
    WSEL = 32'h0000_0020;
    WD = 32'hDEAD_BEEF;
    #1 chk("rd_during_wr", RD1, 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    WE = 1'b0;
    model[5] = 32'hDEAD_BEEF;
    chk("rd_after_wr", RD1, 32'hDEAD_BEEF);

    // x0 stays zero
    wr_reg(0, 32'hFFFF_FFFF);
    RA2 = 5'd0;
    #1;
    chk("x0_read", RD2, 32'd0);
    chk("x0_selerr", 32'(SEL_ERR), 32'd0);

    // random writes and reads; WSEL junk while WE=0
    for (int t = 0; t < 150; t++) begin
      @(negedge CLK);
      we = $urandom_range(0, 1);
      idx = $urandom_range(0, 31);
      d = $urandom;
      WE = 1'(we);
      WSEL = we ? (32'(1) << idx) : $urandom;
      WD = d;
      RA1 = 5'($urandom);
      RA2 = 5'($urandom);
      #1 chk("rnd_rd1_old", RD1, model[RA1]);
      @(posedge CLK);
      @(negedge CLK);
      WE = 1'b0;
      if (we && idx != 0) model[idx] = d;
      chk("rnd_rd1", RD1, model[RA1]);
      chk("rnd_rd2", RD2, model[RA2]);
    end
    chk("rnd_selerr", 32'(SEL_ERR), 32'd0);

    // two-hot select rejected
    @(negedge CLK);
    WE = 1'b1;
    WSEL = 32'h0000_0006;
    WD = ~model[1];
    @(posedge CLK);
    @(negedge CLK);
    WE = 1'b0;
    RA1 = 5'd1;
    RA2 = 5'd2;
    #1;
    chk("bad_sel_r1", RD1, model[1]);
    chk("bad_sel_r2", RD2, model[2]);
    chk("bad_sel_err", 32'(SEL_ERR), 32'd1);
    WE = 1'b1;
    WSEL = 32'h0;
    WD = 32'h1234_5678;
    @(posedge CLK);
    @(negedge CLK);
    WE = 1'b0;
    wr_reg(4, 32'hCAFE_F00D);
    chk("sel_err_sticky", 32'(SEL_ERR), 32'd1);
    RA1 = 5'd4;
    #1 chk("wr_after_err", RD1, 32'hCAFE_F00D);

    // full dump with ready held high
    wr_reg(1, 32'h1122_3344);
    dump_run(1'b0, 1'b0, -1, cyc, n);
    chk("dump_cycles", 32'(cyc), 32'd161);
    chk("dump_bytes", 32'(n), 32'd128);
    chk("d_b0", 32'(rx[0]), 32'h00);
    chk("d_b3", 32'(rx[3]), 32'h00);
    chk("d_b4", 32'(rx[4]), 32'h44);
    chk("d_b5", 32'(rx[5]), 32'h33);
    chk("d_b6", 32'(rx[6]), 32'h22);
    chk("d_b7", 32'(rx[7]), 32'h11);

    // random stalls, write x3 mid-dump, ignored re-request
    @(negedge CLK);
    dump_run(1'b1, 1'b1, -1, cyc, n);
    chk("stall_bytes", 32'(n), 32'd128);

    // reset during SEND of register 7
    @(negedge CLK);
    dump_run(1'b0, 1'b0, 28, cyc, n);
    foreach (model[i]) model[i] = '0;
    @(negedge CLK);
    RST_N = 1'b1;
    chk("post_rst_selerr", 32'(SEL_ERR), 32'd0);
    RA1 = 5'd5;
    #1 chk("post_rst_reg", RD1, 32'd0);
    @(negedge CLK);
    wr_reg(2, 32'hA5C3_0F96);
    dump_run(1'b0, 1'b0, -1, cyc, n);
    chk("restart_cycles", 32'(cyc), 32'd161);
    chk("restart_bytes", 32'(n), 32'd128);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
